// File: rtl/aes_shift_rows_stage.sv
// AES ShiftRows pipeline stage with round tracking and sequencing error flag.
// State layout is column-major: byte (row r, col c) sits at [127-8*(4c+r) -: 8].
// Optional macro AES_SR_SKID_EN: 2-entry skid buffer with registered in_ready.
// Without it, a single output register with in_ready = !out_valid || out_ready.
module aes_shift_rows_stage #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_final,
  output logic         err
);

  localparam logic [3:0] NR_L = 4'(NR);

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  logic         accept;
  logic         xfer;
  logic [127:0] beat_state;
  logic [3:0]   beat_round;
  logic         beat_final;
  logic         beat_err;
  logic [3:0]   cnt_q;
  logic         seen_q;

  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign beat_state = shift_rows(in_state);
  assign beat_final = (beat_round == NR_L);

  // Round number attached to the incoming beat; a continuation with no open
  // block (never started, or already at NR) saturates at NR and flags an error.
  always_comb begin
    beat_round = cnt_q + 4'd1;
    beat_err   = 1'b0;
    if (in_first) begin
      beat_round = 4'd1;
    end else if (!seen_q || cnt_q == NR_L) begin
      beat_round = NR_L;
      beat_err   = 1'b1;
    end
  end

  // Round counter, first-seen flag and sticky error, advanced per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      cnt_q <= beat_round;
      if (in_first) seen_q <= 1'b1;
      if (beat_err) err <= 1'b1;
    end
  end

`ifdef AES_SR_SKID_EN
  logic         rdy_q;
  logic         skid_valid;
  logic [127:0] skid_state;
  logic [3:0]   skid_round;
  logic         skid_final;

  // rdy_q is purely registered; rst gating only forces 0 while reset is held.
  assign in_ready = rdy_q && !rst;

  // Output register is the head, skid entry the tail; the tail refills the
  // head on transfer, otherwise a new beat goes straight to the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_state  <= '0;
      out_round  <= '0;
      out_final  <= 1'b0;
      skid_valid <= 1'b0;
      skid_state <= '0;
      skid_round <= '0;
      skid_final <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      if (!out_valid || xfer) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_state  <= skid_state;
          out_round  <= skid_round;
          out_final  <= skid_final;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_state <= beat_state;
          out_round <= beat_round;
          out_final <= beat_final;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_state <= beat_state;
        skid_round <= beat_round;
        skid_final <= beat_final;
      end
      // Both entries occupied next cycle only if the head stays and the tail fills.
      rdy_q <= !(out_valid && !xfer && (skid_valid || accept));
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  // Single output register: load on accept, empty on transfer without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      out_final <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_state <= beat_state;
      out_round <= beat_round;
      out_final <= beat_final;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// Directed bench for aes_shift_rows_stage (NR=10). Inputs change and outputs
// are sampled on the falling clock edge. Expected states use the known vector
// 000102..0f -> 00050a0f..; XOR with a byte replicated in all 16 positions
// commutes with ShiftRows, giving further hand-derivable vectors.
module tb_aes_shift_rows_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_final;
  logic         err;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VEC_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_OUT = 128'h00050a0f04090e03080d02070c01060b;

  aes_shift_rows_stage #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .out_round(out_round),
    .out_final(out_final),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_state = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_state !== '0) begin errors++; $display("FAIL rst_out_state got %h want 0", out_state); end
    checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL rst_out_round got %0d want 0", out_round); end
    checks++; if (out_final !== 1'b0) begin errors++; $display("FAIL rst_out_final got %b want 0", out_final); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vector();
    in_valid = 1'b1; in_first = 1'b1; in_state = VEC_IN; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec_valid got %b want 1", out_valid); end
    checks++; if (out_state !== VEC_OUT) begin errors++; $display("FAIL vec_state got %h want %h", out_state, VEC_OUT); end
    checks++; if (out_round !== 4'd1) begin errors++; $display("FAIL vec_round got %0d want 1", out_round); end
    checks++; if (out_final !== 1'b0) begin errors++; $display("FAIL vec_final got %b want 0", out_final); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_drain got %b want 0", out_valid); end
  endtask

  task automatic test_restart();
    logic       firsts [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] rounds [4] = '{4'd1, 4'd2, 4'd3, 4'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_first = firsts[i]; in_state = VEC_IN;
      @(negedge clk);
      checks++; if (out_round !== rounds[i]) begin errors++; $display("FAIL restart_round[%0d] got %0d want %0d", i, out_round, rounds[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL restart_err[%0d] got %b want 0", i, err); end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] k;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k = 8'(i * 17);
      in_valid = 1'b1; in_first = (i == 0); in_state = VEC_IN ^ {16{k}};
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_round !== 4'(i + 1)) begin errors++; $display("FAIL b2b_round[%0d] got %0d want %0d", i, out_round, i + 1); end
      checks++; if (out_final !== (i == 9)) begin errors++; $display("FAIL b2b_final[%0d] got %b want %b", i, out_final, (i == 9)); end
      checks++; if (out_state !== (VEC_OUT ^ {16{k}})) begin errors++; $display("FAIL b2b_state[%0d] got %h want %h", i, out_state, VEC_OUT ^ {16{k}}); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d] got %b want 0", i, err); end
    end
    // eleventh beat without in_first overruns the block
    in_first = 1'b0; in_state = VEC_IN;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_round !== 4'd10) begin errors++; $display("FAIL overrun_round got %0d want 10", out_round); end
    checks++; if (out_final !== 1'b1) begin errors++; $display("FAIL overrun_final got %b want 1", out_final); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b want 1", err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d] got %b want 1", i, err); end
    end
    // a new block does not clear the sticky error
    in_valid = 1'b1; in_first = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (err !== 1'b1 || out_round !== 4'd1) begin errors++; $display("FAIL err_after_first got err=%b round=%0d want err=1 round=1", err, out_round); end
    @(negedge clk);
  endtask

  task automatic test_rst_midflight();
    in_valid = 1'b1; in_first = 1'b1; in_state = VEC_IN; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_held got %b want 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL mid_rst_round got %0d want 0", out_round); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_dropped[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_unseen_first();
    out_ready = 1'b1;
    in_valid = 1'b1; in_first = 1'b0; in_state = VEC_IN;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_round !== 4'd10 || out_final !== 1'b1) begin errors++; $display("FAIL unseen_round got round=%0d final=%b want round=10 final=1", out_round, out_final); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unseen_err got %b want 1", err); end
    checks++; if (out_state !== VEC_OUT) begin errors++; $display("FAIL unseen_state got %h want %h", out_state, VEC_OUT); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [7:0] keys [4] = '{8'h00, 8'h11, 8'h5a, 8'hc3};
    int sent = 0;
    int recv = 0;
    logic want_rdy;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      in_first  = (sent == 0);
      in_state  = VEC_IN ^ {16{keys[sent < 4 ? sent : 0]}};
      #1;
      if (cyc >= 2 && cyc <= 3) begin
        checks++; if (out_state !== VEC_OUT || out_round !== 4'd1) begin errors++; $display("FAIL stall_hold[%0d] got %h/%0d want %h/1", cyc, out_state, out_round, VEC_OUT); end
      end
      if (cyc >= 1 && cyc <= 3) begin
`ifdef AES_SR_SKID_EN
        want_rdy = (cyc == 1);
`else
        want_rdy = 1'b0;
`endif
        checks++; if (in_ready !== want_rdy) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want %b", cyc, in_ready, want_rdy); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (recv >= 4 || out_state !== (VEC_OUT ^ {16{keys[recv < 4 ? recv : 0]}}) || out_round !== 4'(recv + 1)) begin
          errors++; $display("FAIL stall_order[%0d] got %h/%0d", recv, out_state, out_round);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (recv !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", recv); end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_restart();
    test_back_to_back();
    test_rst_midflight();
    test_unseen_first();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
